value_storage_bank: RTL and testbench

Parametrised successor to the single-value button/IO storage. Holds `NUM_CH` independent `WIDTH`-bit registers and edits the currently selected one from debounced front-panel buttons (increment, shift-left, clear, send, next-channel). Accepts direct loads from the IO bus. Queues "send" requests in a small output FIFO with a proper valid/ready handshake. Sits between the board button/LED pins and the RISC-V IO bridge.

---
 rtl/value_storage_pkg.sv | 31 +++
 rtl/value_storage_fifo.sv | 61 ++++++
 rtl/value_storage_bank.sv | 121 ++++++++++++
 tb/tb_value_storage_bank.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/value_storage_pkg.sv
// Shared button indices, op encoding and the button-priority decoder
// for the value storage bank.
package value_storage_pkg;

    localparam int unsigned NUM_BTN  = 5;
    localparam int unsigned BTN_INC  = 0;
    localparam int unsigned BTN_SHL  = 1;
    localparam int unsigned BTN_CLR  = 2;
    localparam int unsigned BTN_SEND = 3;
    localparam int unsigned BTN_NEXT = 4;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_INC,
        OP_SHL,
        OP_CLR,
        OP_SEND,
        OP_NEXT
    } op_t;

    // Lowest button index wins; simultaneous presses are swallowed.
    function automatic op_t decode_op(input logic [NUM_BTN-1:0] press);
        if (press[BTN_INC])       return OP_INC;
        else if (press[BTN_SHL])  return OP_SHL;
        else if (press[BTN_CLR])  return OP_CLR;
        else if (press[BTN_SEND]) return OP_SEND;
        else if (press[BTN_NEXT]) return OP_NEXT;
        else                      return OP_NONE;
    endfunction

endpackage

// File: rtl/value_storage_fifo.sv
// Synchronous send queue with full/empty flags and simultaneous push/pop.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module value_storage_fifo #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head is forced to zero when empty so stale entries never show after reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/value_storage_bank.sv
// Bank of NUM_CH editable value registers driven by debounced front-panel
// buttons and IO-bus loads, with a valid/ready send queue.
module value_storage_bank
    import value_storage_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LED_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4:0]                buttons,
    input  logic                      timer_active_trigger,
    input  logic                      in_valid,
    input  logic [$clog2(NUM_CH)-1:0] in_channel,
    input  logic [WIDTH-1:0]          in_value,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_value,
    output logic [$clog2(NUM_CH)-1:0] out_channel,
    output logic [$clog2(NUM_CH)-1:0] sel_channel,
    output logic                      overflow,
    output logic [LED_WIDTH-1:0]      leds
);

    localparam int unsigned CH_W   = $clog2(NUM_CH);
    localparam int unsigned DATA_W = CH_W + WIDTH;

    logic [NUM_BTN-1:0] btn_q;
    logic [NUM_BTN-1:0] press;
    op_t                op;
    logic               load_ok;
    logic [WIDTH-1:0]   regs [NUM_CH];
    logic [WIDTH-1:0]   cur_value;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q <= '0;
        end else if (timer_active_trigger) begin
            btn_q <= buttons;
        end
    end

    assign press = buttons & ~btn_q & {NUM_BTN{timer_active_trigger}};

    always_comb begin
        op = decode_op(press);
    end

    // With a power-of-two channel count every in_channel value is valid.
    if (NUM_CH == (1 << CH_W)) begin : g_load_full_range
        assign load_ok = in_valid;
    end else begin : g_load_checked
        assign load_ok = in_valid && (32'(in_channel) < NUM_CH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (load_ok && in_channel == CH_W'(i)) begin
                    regs[i] <= in_value;
                end else if (sel_channel == CH_W'(i)) begin
                    case (op)
                        OP_INC:  regs[i] <= regs[i] + 1'b1;
                        OP_SHL:  regs[i] <= {regs[i][WIDTH-2:0], 1'b0};
                        OP_CLR:  regs[i] <= '0;
                        default: regs[i] <= regs[i];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_channel <= '0;
        end else if (op == OP_NEXT) begin
            sel_channel <= (sel_channel == CH_W'(NUM_CH - 1)) ? '0 : sel_channel + 1'b1;
        end
    end

    assign cur_value = regs[sel_channel];
    assign leds      = cur_value[LED_WIDTH-1:0];

    // Send captures the pre-load register value, even if a load hits it this cycle.
    assign push      = (op == OP_SEND);
    assign pop       = out_valid & out_ready;
    assign out_valid = ~fifo_empty;

    value_storage_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({sel_channel, cur_value}),
        .pop       (pop),
        .pop_data  ({out_channel, out_value}),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_value_storage_bank.sv
// Directed self-checking bench for value_storage_bank with default parameters.
module tb_value_storage_bank;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned LED_WIDTH  = 4;
    localparam int unsigned CH_W       = 2;

    localparam int unsigned B_INC  = 0;
    localparam int unsigned B_SHL  = 1;
    localparam int unsigned B_CLR  = 2;
    localparam int unsigned B_SEND = 3;
    localparam int unsigned B_NEXT = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [4:0]           buttons;
    logic                 timer_active_trigger;
    logic                 in_valid;
    logic [CH_W-1:0]      in_channel;
    logic [WIDTH-1:0]     in_value;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_value;
    logic [CH_W-1:0]      out_channel;
    logic [CH_W-1:0]      sel_channel;
    logic                 overflow;
    logic [LED_WIDTH-1:0] leds;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    value_storage_bank #(
        .WIDTH      (WIDTH),
        .NUM_CH     (NUM_CH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LED_WIDTH  (LED_WIDTH)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .buttons              (buttons),
        .timer_active_trigger (timer_active_trigger),
        .in_valid             (in_valid),
        .in_channel           (in_channel),
        .in_value             (in_value),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_value            (out_value),
        .out_channel          (out_channel),
        .sel_channel          (sel_channel),
        .overflow             (overflow),
        .leds                 (leds)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int unsigned idx);
        buttons      = '0;
        buttons[idx] = 1'b1;
        cycle();
    endtask

    task automatic rel();
        buttons = '0;
        cycle();
    endtask

    task automatic load(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] v);
        in_valid   = 1'b1;
        in_channel = ch;
        in_value   = v;
        cycle();
        in_valid   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        buttons = '0;
        timer_active_trigger = 1'b1;
        in_valid = 1'b0;
        in_channel = '0;
        in_value = '0;
        out_ready = 1'b0;
        cycle();
        cycle();
        vectors++;
        if ({out_valid, overflow, leds, sel_channel, out_value, out_channel} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%0b ovf=%0b leds=%0h sel=%0d val=%0h ch=%0d required all 0",
                     out_valid, overflow, leds, sel_channel, out_value, out_channel);
        end
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_inc_shl();
        hold(B_INC);
        vectors++;
        if (leds !== 4'd1) begin miscompares++; $display("FAIL inc1: leds=%0d required 1", leds); end
        rel();
        hold(B_INC);
        vectors++;
        if (leds !== 4'd2) begin miscompares++; $display("FAIL inc2: leds=%0d required 2", leds); end
        rel();
        hold(B_SHL);
        vectors++;
        if (leds !== 4'd4) begin miscompares++; $display("FAIL shl: leds=%0d required 4", leds); end
        rel();
        buttons = 5'b00001;
        for (int i = 0; i < 5; i++) cycle();
        rel();
        vectors++;
        if (leds !== 4'd5) begin miscompares++; $display("FAIL inc_hold: leds=%0d required 5", leds); end
    endtask

    task automatic test_wrap();
        load(2'd0, 8'hFF);
        hold(B_INC);
        rel();
        hold(B_SEND);
        vectors++;
        if (out_valid !== 1'b1 || out_value !== 8'h00 || out_channel !== 2'd0) begin
            miscompares++;
            $display("FAIL inc_wrap: valid=%0b val=%0h ch=%0d required 1/00/0", out_valid, out_value, out_channel);
        end
        out_ready = 1'b1;
        rel();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL pop_empty: valid=%0b required 0", out_valid); end
        load(2'd0, 8'h81);
        hold(B_SHL);
        rel();
        hold(B_SEND);
        vectors++;
        if (out_value !== 8'h02) begin miscompares++; $display("FAIL shl_msb: val=%0h required 02", out_value); end
        out_ready = 1'b1;
        rel();
        out_ready = 1'b0;
    endtask

    task automatic test_next();
        for (int i = 1; i <= 4; i++) begin
            hold(B_NEXT);
            vectors++;
            if (sel_channel !== CH_W'(i % 4)) begin
                miscompares++;
                $display("FAIL next_%0d: sel=%0d required %0d", i, sel_channel, i % 4);
            end
            rel();
        end
        load(2'd2, 8'd22);
        vectors++;
        if (leds !== 4'd2) begin miscompares++; $display("FAIL load_other: leds=%0d required 2", leds); end
        hold(B_NEXT); rel();
        hold(B_NEXT); rel();
        vectors++;
        if (leds !== 4'd6 || sel_channel !== 2'd2) begin
            miscompares++;
            $display("FAIL load_ch2: leds=%0d sel=%0d required 6/2", leds, sel_channel);
        end
        hold(B_NEXT); rel();
        hold(B_NEXT); rel();
    endtask

    task automatic test_collision();
        buttons = 5'b00001;
        load(2'd0, 8'd40);
        rel();
        hold(B_SEND);
        vectors++;
        if (out_value !== 8'd40) begin miscompares++; $display("FAIL load_vs_inc: val=%0d required 40", out_value); end
        out_ready = 1'b1;
        rel();
        out_ready = 1'b0;
        buttons = 5'b01000;
        load(2'd0, 8'd50);
        vectors++;
        if (out_value !== 8'd40 || leds !== 4'd2) begin
            miscompares++;
            $display("FAIL load_vs_send: val=%0d leds=%0d required 40/2", out_value, leds);
        end
        out_ready = 1'b1;
        rel();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        load(2'd0, 8'h11);
        hold(B_SEND); rel();
        hold(B_NEXT); rel();
        load(2'd1, 8'h22);
        hold(B_SEND); rel();
        hold(B_NEXT); rel();
        load(2'd2, 8'h33);
        hold(B_SEND); rel();
        hold(B_NEXT); rel();
        hold(B_NEXT); rel();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_value !== WIDTH'(8'h11 * (i + 1)) || out_channel !== CH_W'(i)) begin
                miscompares++;
                $display("FAIL b2b_%0d: valid=%0b val=%0h ch=%0d required 1/%0h/%0d",
                         i, out_valid, out_value, out_channel, 8'h11 * (i + 1), i);
            end
            cycle();
        end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: valid=%0b required 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        load(2'd0, 8'd7);
        for (int i = 0; i < 4; i++) begin
            hold(B_SEND); rel();
        end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_full: ovf=%0b required 0", overflow); end
        hold(B_SEND); rel();
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_drop: ovf=%0b required 1", overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_value !== 8'd7 || out_channel !== 2'd0) begin
                miscompares++;
                $display("FAIL ovf_pop_%0d: valid=%0b val=%0d ch=%0d required 1/7/0", i, out_valid, out_value, out_channel);
            end
            cycle();
        end
        vectors++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_drain: valid=%0b ovf=%0b required 0/1", out_valid, overflow);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_tick();
        timer_active_trigger = 1'b0;
        hold(B_CLR);
        cycle();
        vectors++;
        if (leds !== 4'd7) begin miscompares++; $display("FAIL tick_low: leds=%0d required 7", leds); end
        timer_active_trigger = 1'b1;
        cycle();
        vectors++;
        if (leds !== 4'd0) begin miscompares++; $display("FAIL tick_high: leds=%0d required 0", leds); end
        rel();
    endtask

    task automatic test_reset_mid();
        load(2'd0, 8'd9);
        hold(B_SEND); rel();
        hold(B_NEXT); rel();
        vectors++;
        if (out_valid !== 1'b1 || sel_channel !== 2'd1) begin
            miscompares++;
            $display("FAIL pre_reset: valid=%0b sel=%0d required 1/1", out_valid, sel_channel);
        end
        reset = 1'b1;
        buttons = 5'b00001;
        cycle();
        vectors++;
        if ({out_valid, overflow, leds, sel_channel, out_value, out_channel} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%0b ovf=%0b leds=%0h sel=%0d val=%0h ch=%0d required all 0",
                     out_valid, overflow, leds, sel_channel, out_value, out_channel);
        end
        reset = 1'b0;
        cycle();
        vectors++;
        if (leds !== 4'd1) begin miscompares++; $display("FAIL held_through_reset: leds=%0d required 1", leds); end
        rel();
    endtask

    initial begin
        test_reset();
        test_inc_shl();
        test_wrap();
        test_next();
        test_collision();
        test_back_to_back();
        test_overflow();
        test_tick();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
